// File: rtl/testport_pkg.sv
// testport_pkg
//   Shared constants and types for the test-port capture block.
//   - TEST_PORT_DEF    : default word address of the test port
//   - BEGIN_SYMBOL_DEF : default store value that arms the watchdog
//   - out_state_t      : output pulse FSM state encoding
//   - sat_inc16        : saturating 16-bit increment
package testport_pkg;

    localparam logic [29:0] TEST_PORT_DEF    = 30'hFF;
    localparam logic [31:0] BEGIN_SYMBOL_DEF = 32'h0000_0168;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } out_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/testport_fifo.sv
// testport_fifo
//   Synchronous FIFO holding captured test-port store data.
//   Ports:
//     clk, rst          : clock, synchronous active-low reset
//     push, wdata       : write request and data
//     pop               : read request (head advances at the edge)
//     rdata             : current head entry (valid when !empty)
//     full, empty       : occupancy flags
//   A push while full is accepted only if a pop happens in the same cycle.
module testport_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/testport_capture.sv
// testport_capture
//   Snoops the data-memory write port, captures completed stores to the
//   test port, buffers them and replays each as a single-cycle wen pulse
//   followed by at least GAP_CYCLES idle cycles.
//   Ports:
//     clk, rst                        : clock, synchronous active-low reset
//     mem_addr/mem_wdata/mem_wen/
//     mem_stall                       : processor data-memory write interface
//     addr/data/wen                   : registered pulse output to the checker
//     overflow                        : sticky, an event was dropped (FIFO full)
//     event_cnt                       : pulses issued, saturating
//     hang                            : sticky watchdog flag
//   Optional feature: define TESTPORT_WATCHDOG_EN to build the watchdog;
//   otherwise hang is tied to 0.
//
//   Output FSM
//     state | meaning
//     IDLE  | waiting for a buffered event
//     PULSE | wen high, addr/data presenting the popped event
//     GAP   | outputs low, counting down the forced idle gap
module testport_capture
    import testport_pkg::*;
#(
    parameter logic [29:0] TEST_PORT    = TEST_PORT_DEF,
    parameter logic [31:0] BEGIN_SYMBOL = BEGIN_SYMBOL_DEF,
    parameter int          DEPTH        = 8,
    parameter int          GAP_CYCLES   = 1,
    parameter logic [15:0] WDOG_LIMIT   = 16'd4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wen,
    input  logic        mem_stall,
    output logic [29:0] addr,
    output logic [31:0] data,
    output logic        wen,
    output logic        overflow,
    output logic [15:0] event_cnt,
    output logic        hang
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    out_state_t  state;
    logic [3:0]  gap_cnt;
    logic        capture;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;

    // Stalled cycles repeat the same store, so only the completing cycle counts.
    assign capture = mem_wen && !mem_stall && (mem_addr == TEST_PORT);

    // The last gap cycle doubles as the IDLE decision cycle so that events
    // can be issued every 1+GAP_CYCLES cycles.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == GAP) && (gap_cnt == 4'd0)));

    testport_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata (mem_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gap_cnt   <= 4'd0;
            wen       <= 1'b0;
            addr      <= '0;
            data      <= '0;
            event_cnt <= 16'd0;
            overflow  <= 1'b0;
        end else begin
            if (capture && fifo_full && !fifo_pop) overflow <= 1'b1;

            if (fifo_pop) begin
                state     <= PULSE;
                wen       <= 1'b1;
                addr      <= TEST_PORT;
                data      <= fifo_rdata;
                event_cnt <= sat_inc16(event_cnt);
            end else begin
                case (state)
                    IDLE: ;
                    PULSE: begin
                        state   <= GAP;
                        wen     <= 1'b0;
                        addr    <= '0;
                        data    <= '0;
                        gap_cnt <= GAP_LOAD;
                    end
                    GAP: begin
                        if (gap_cnt == 4'd0) state <= IDLE;
                        else                 gap_cnt <= gap_cnt - 4'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TESTPORT_WATCHDOG_EN
    // Down-counter holding cycles remaining until the hang limit; a
    // capture reloads it, which is the same as clearing an elapsed count.
    logic        wdog_armed;
    logic [15:0] wdog_cnt;
    logic        hang_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_armed <= 1'b0;
            wdog_cnt   <= 16'd0;
            hang_r     <= 1'b0;
        end else if (!hang_r) begin
            if (capture) begin
                wdog_cnt <= WDOG_LIMIT;
                if (mem_wdata == BEGIN_SYMBOL) wdog_armed <= 1'b1;
            end else if (wdog_armed) begin
                if (wdog_cnt <= 16'd1) begin
                    hang_r   <= 1'b1;
                    wdog_cnt <= 16'd0;
                end else begin
                    wdog_cnt <= wdog_cnt - 16'd1;
                end
            end
        end
    end

    assign hang = hang_r;
`else
    assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_testport_capture.sv
module tb_testport_capture;
    import testport_pkg::*;

`ifdef TESTPORT_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_wen = 1'b0;
    logic        mem_stall = 1'b0;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        overflow;
    logic [15:0] event_cnt;
    logic        hang;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int npulse = 0;
    logic prev_wen = 1'b0;

    logic [31:0] exp_q[$];
    int          pulse_cyc[$];

    testport_capture #(
        .TEST_PORT    (30'hFF),
        .BEGIN_SYMBOL (32'h168),
        .DEPTH        (8),
        .GAP_CYCLES   (1),
        .WDOG_LIMIT   (16'd20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_stall (mem_stall),
        .addr      (addr),
        .data      (data),
        .wen       (wen),
        .overflow  (overflow),
        .event_cnt (event_cnt),
        .hang      (hang)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: every pulse is matched against the expected queue.
    always @(posedge clk) begin
        logic [31:0] expv;
        #1;
        if (rst) begin
            if (wen) begin
                npulse++;
                pulse_cyc.push_back(cyc);
                chk("pulse_addr", 32'(addr), 32'hFF);
                chk("pulse_sep", 32'(prev_wen), 32'd0);
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                chk("pulse_data", data, expv);
            end else begin
                chk("idle_addr", 32'(addr), 32'd0);
                chk("idle_data", data, 32'd0);
            end
            prev_wen = wen;
        end else begin
            prev_wen = 1'b0;
        end
    end

    task automatic store(input logic [29:0] a, input logic [31:0] d,
                         input int stalls, input bit expect_it);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_wen   = 1'b1;
        mem_stall = (stalls != 0);
        repeat (stalls) @(negedge clk);
        mem_stall = 1'b0;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic quiet();
        @(negedge clk);
        mem_wen   = 1'b0;
        mem_stall = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(event_cnt), 32'd0);
        chk("rst_hang", 32'(hang), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single store of BEGIN_SYMBOL; latency and watchdog timing from its capture
        store(30'hFF, 32'h168, 0, 1'b1);
        quiet();                                   // after capture edge
        chk("lat_wen_t1", 32'(wen), 32'd0);
        @(negedge clk);                            // capture + 2
        chk("lat_wen_t2", 32'(wen), 32'd1);
        chk("lat_data_t2", data, 32'h168);
        @(negedge clk);
        chk("single_cnt", 32'(event_cnt), 32'd1);
        repeat (17) @(negedge clk);                // 20 edges after capture edge
        chk("hang_before", 32'(hang), 32'd0);
        @(negedge clk);
        chk("hang_at_limit", 32'(hang), 32'(WD_ON));
        drain("single_drain");

        // Stalled store: one event only, none while stalled
        n0 = npulse;
        store(30'hFF, 32'h0000_00A5, 3, 1'b1);
        chk("stall_no_early", 32'(npulse - n0), 32'd0);
        quiet();
        drain("stall_drain");
        chk("stall_count", 32'(npulse - n0), 32'd1);

        // Four back-to-back stores
        n0 = pulse_cyc.size();
        for (int i = 1; i <= 4; i++) store(30'hFF, 32'(i), 0, 1'b1);
        quiet();
        drain("four_drain");
        chk("four_count", 32'(pulse_cyc.size() - n0), 32'd4);
        for (int k = 1; k < 4; k++)
            chk("four_spacing", 32'(pulse_cyc[n0+k] - pulse_cyc[n0+k-1]), 32'd2);
        chk("four_no_ovf", 32'(overflow), 32'd0);

        // Store to a non-test-port address
        n0 = npulse;
        store(30'hFE, 32'h55, 0, 1'b0);
        quiet();
        repeat (8) @(negedge clk);
        chk("nonport_pulses", 32'(npulse - n0), 32'd0);
        chk("nonport_wen", 32'(wen), 32'd0);

        // Overflow: the FIFO drains one event per 2 cycles, so the 17th
        // consecutive store finds it full with no pop and is dropped.
        n0 = npulse;
        for (int i = 0; i < 17; i++) store(30'hFF, 32'h100 + 32'(i), 0, (i < 16));
        quiet();
        chk("ovf_set", 32'(overflow), 32'd1);
        drain("ovf_drain");
        chk("ovf_count", 32'(npulse - n0), 32'd16);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("total_cnt", 32'(event_cnt), 32'd22);
        chk("hang_sticky", 32'(hang), 32'(WD_ON));

        // Reset mid-operation discards buffered events
        for (int i = 0; i < 4; i++) store(30'hFF, 32'h200 + 32'(i), 0, 1'b1);
        quiet();
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_wen", 32'(wen), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_cnt", 32'(event_cnt), 32'd0);
        chk("mid_rst_hang", 32'(hang), 32'd0);
        rst = 1'b1;
        n0 = npulse;
        repeat (20) @(negedge clk);
        chk("post_rst_pulses", 32'(npulse - n0), 32'd0);
        chk("post_rst_cnt", 32'(event_cnt), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
